// File: rtl/rtc_bank_read_seq.sv
// RTC bank read sequencer.
// For every bank selected at start, writes the transfer command (CMD_BASE+bank,
// CMD_DATA), then reads NUM_REGS addresses from addr_table_i into a shadow buffer.
// The shadow is copied to rd_data_o in one cycle, so a consumer never sees a
// half-updated time value. Each bus request is covered by a wait timeout.
// Optional build macro: RTC_BCD_CHECK_EN. When it is defined, every read byte
// must be valid BCD. A bank with a bad byte is not committed, and the sequence
// ends with err_o instead of done_o.
//
// state   | meaning
// IDLE    | waiting for start_i
// CMD_REQ | transfer command write in progress for bank_q
// RD_REQ  | register reads for bank_q; bus_req_q low = gap cycle before the next read
// COMMIT  | copy shadow to rd_data for bank_q, then the next bank or FINISH
// FINISH  | one done (or err) pulse, then IDLE
module rtc_bank_read_seq #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                NUM_BANKS   = 2,
    parameter int                NUM_REGS    = 6,
    parameter logic [ADDR_W-1:0] CMD_BASE    = 8'hF1,
    parameter logic [DATA_W-1:0] CMD_DATA    = 8'h01,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic [NUM_BANKS-1:0]                  bank_mask_i,
    input  logic [NUM_BANKS*NUM_REGS*ADDR_W-1:0]  addr_table_i,
    output logic                                  bus_req_o,
    output logic                                  bus_wr_o,
    output logic [ADDR_W-1:0]                     bus_addr_o,
    output logic [DATA_W-1:0]                     bus_wdata_o,
    input  logic                                  bus_ack_i,
    input  logic [DATA_W-1:0]                     bus_rdata_i,
    output logic [NUM_BANKS*NUM_REGS*DATA_W-1:0]  rd_data_o,
    output logic [NUM_BANKS-1:0]                  bank_upd_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o
);

    localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int BANK_BITS = NUM_REGS * DATA_W;
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] REG_LAST = RW'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, CMD_REQ, RD_REQ, COMMIT, FINISH} state_t;

    state_t                              state_q;
    logic [BW-1:0]                       bank_q;
    logic [NUM_BANKS-1:0]                rem_q;
    logic [RW-1:0]                       reg_q;
    logic [7:0]                          tmr_q;
    logic [BANK_BITS-1:0]                shadow_q;
    logic [NUM_BANKS*BANK_BITS-1:0]      rd_data_q;
    logic                                bus_req_q;
    logic                                bus_wr_q;
    logic [ADDR_W-1:0]                   bus_addr_q;
    logic [DATA_W-1:0]                   bus_wdata_q;
    logic [NUM_BANKS-1:0]                bank_upd_q;
    logic                                busy_q;
    logic                                done_q;
    logic                                err_q;
    logic                                bank_bad_q;
    logic                                seq_bad_q;

    logic [NUM_BANKS-1:0]                src_d;
    logic [BW-1:0]                       bank_d;
    logic [NUM_BANKS-1:0]                sel_d;
    logic [ADDR_W-1:0]                   rd_addr_d;
    logic                                byte_bad_d;
    logic                                tmo_d;

    function automatic logic [BW-1:0] low_idx(input logic [NUM_BANKS-1:0] m);
        low_idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (m[i]) low_idx = BW'(i);
        end
    endfunction

    // Next bank to launch: from the live mask at start, from the remaining set after a commit
    always_comb begin
        src_d      = (state_q == IDLE) ? bank_mask_i : rem_q;
        bank_d     = low_idx(src_d);
        sel_d      = NUM_BANKS'(1) << bank_d;
        rd_addr_d  = addr_table_i[(int'(bank_q) * NUM_REGS + int'(reg_q)) * ADDR_W +: ADDR_W];
        tmo_d      = bus_req_q && !bus_ack_i && (tmr_q == TMO_LAST);
        byte_bad_d = 1'b0;
`ifdef RTC_BCD_CHECK_EN
        for (int n = 0; n < DATA_W / 4; n++) begin
            if (bus_rdata_i[n*4 +: 4] > 4'd9) byte_bad_d = 1'b1;
        end
`endif
    end

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            bank_q      <= '0;
            rem_q       <= '0;
            reg_q       <= '0;
            tmr_q       <= '0;
            shadow_q    <= '0;
            rd_data_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bank_upd_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bank_bad_q  <= 1'b0;
            seq_bad_q   <= 1'b0;
        end else begin
            bank_upd_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (bank_mask_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q      <= 1'b1;
                            seq_bad_q   <= 1'b0;
                            state_q     <= CMD_REQ;
                            bank_q      <= bank_d;
                            rem_q       <= src_d & ~sel_d;
                            bus_req_q   <= 1'b1;
                            bus_wr_q    <= 1'b1;
                            bus_addr_q  <= CMD_BASE + ADDR_W'(bank_d);
                            bus_wdata_q <= CMD_DATA;
                            tmr_q       <= '0;
                            bank_bad_q  <= 1'b0;
                        end
                    end
                end
                CMD_REQ, RD_REQ: begin
                    if (!bus_req_q) begin
                        // gap cycle done: issue the next register read
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= 1'b0;
                        bus_addr_q  <= rd_addr_d;
                        bus_wdata_q <= '0;
                        tmr_q       <= '0;
                    end else if (bus_ack_i) begin
                        bus_req_q <= 1'b0;
                        if (state_q == CMD_REQ) begin
                            state_q <= RD_REQ;
                            reg_q   <= '0;
                        end else begin
                            shadow_q[int'(reg_q) * DATA_W +: DATA_W] <= bus_rdata_i;
                            bank_bad_q <= bank_bad_q | byte_bad_d;
                            if (reg_q == REG_LAST) state_q <= COMMIT;
                            else                   reg_q   <= reg_q + RW'(1);
                        end
                    end else if (tmo_d) begin
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                COMMIT: begin
                    if (!bank_bad_q) begin
                        rd_data_q[int'(bank_q) * BANK_BITS +: BANK_BITS] <= shadow_q;
                        bank_upd_q <= NUM_BANKS'(1) << bank_q;
                    end else begin
                        seq_bad_q <= 1'b1;
                    end
                    if (rem_q != '0) begin
                        state_q     <= CMD_REQ;
                        bank_q      <= bank_d;
                        rem_q       <= src_d & ~sel_d;
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= 1'b1;
                        bus_addr_q  <= CMD_BASE + ADDR_W'(bank_d);
                        bus_wdata_q <= CMD_DATA;
                        tmr_q       <= '0;
                        bank_bad_q  <= 1'b0;
                    end else begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (seq_bad_q) err_q  <= 1'b1;
                    else           done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_wr_o    = bus_wr_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign rd_data_o   = rd_data_q;
    assign bank_upd_o  = bank_upd_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rtc_bank_read_seq.sv
// Directed testbench for rtc_bank_read_seq (default parameters).
module tb_rtc_bank_read_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  bank_mask;
    logic [95:0] addr_table;
    logic        bus_req;
    logic        bus_wr;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic [95:0] rd_data;
    logic [1:0]  bank_upd;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int nx     = 0;

    localparam logic [47:0] VA  = 48'h161225123059;
    localparam logic [47:0] VB0 = 48'h060504030201;
    localparam logic [47:0] VB1 = 48'h665544332211;
    localparam logic [47:0] VD0 = 48'h240718092345;
    localparam logic [47:0] VE1 = 48'h868584838281;
    localparam logic [47:0] VF0 = 48'h000000345A12;
    localparam logic [47:0] VF1 = 48'h949596979899;
    localparam logic [47:0] VG0 = 48'h605040302010;

    rtc_bank_read_seq dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .bank_mask_i  (bank_mask),
        .addr_table_i (addr_table),
        .bus_req_o    (bus_req),
        .bus_wr_o     (bus_wr),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_ack_i    (bus_ack),
        .bus_rdata_i  (bus_rdata),
        .rd_data_o    (rd_data),
        .bank_upd_o   (bank_upd),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int b, input int r);
        return 8'(b * 16 + r + 2);
    endfunction

    // Waits for a request, checks it, holds for dly cycles, then acks with rdata.
    task automatic xact(input string tag, input logic ewr, input logic [7:0] eaddr,
                        input logic [7:0] ewd, input int dly, input logic [7:0] rdata);
        int n = 0;
        while (bus_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("%s req", tag), 64'(bus_req), 64'(1));
        chk($sformatf("%s wr", tag), 64'(bus_wr), 64'(ewr));
        chk($sformatf("%s addr", tag), 64'(bus_addr), 64'(eaddr));
        if (ewr) chk($sformatf("%s wdata", tag), 64'(bus_wdata), 64'(ewd));
        repeat (dly) tick();
        chk($sformatf("%s hold", tag), 64'({bus_req, bus_wr, bus_addr}), 64'({1'b1, ewr, eaddr}));
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        chk($sformatf("%s gap", tag), 64'(bus_req), 64'(0));
        nx++;
    endtask

    task automatic run_bank(input string tag, input int b, input logic [47:0] vals, input int dly);
        xact($sformatf("%s cmd", tag), 1'b1, 8'(8'hF1 + b), 8'h01, dly, 8'h00);
        for (int r = 0; r < 6; r++)
            xact($sformatf("%s rd%0d", tag, r), 1'b0, addr_of(b, r), 8'h00, dly, vals[r*8 +: 8]);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        bank_mask = 2'b00;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 6; r++)
                addr_table[(b*6 + r)*8 +: 8] = addr_of(b, r);
        repeat (2) tick();
        chk("reset ctl", 64'({bus_req, bus_wr, busy, done, err, bank_upd}), 64'(0));
        chk("reset bus", 64'({bus_addr, bus_wdata}), 64'(0));
        chk("reset rd0", 64'(rd_data[47:0]), 64'(0));
        chk("reset rd1", 64'(rd_data[95:48]), 64'(0));
        reset = 1'b0;
        tick();

        // single bank, ack after 3 cycles
        bank_mask = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("A busy req", 64'({busy, bus_req}), 64'(2'b11));
        run_bank("A", 0, VA, 3);
        tick();
        chk("A upd", 64'(bank_upd), 64'(2'b01));
        chk("A rd0", 64'(rd_data[47:0]), 64'(VA));
        chk("A rd1", 64'(rd_data[95:48]), 64'(0));
        chk("A no early done", 64'(done), 64'(0));
        tick();
        chk("A done", 64'({done, busy, err, bank_upd}), 64'(5'b10000));
        tick();
        chk("A done pulse", 64'(done), 64'(0));

        // both banks; start and mask changes mid-sequence must be ignored
        nx = 0;
        bank_mask = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        bank_mask = 2'b00;
        xact("B0 cmd", 1'b1, 8'hF1, 8'h01, 1, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("B start ignored", 64'({done, err, busy}), 64'(3'b001));
        for (int r = 0; r < 6; r++)
            xact($sformatf("B0 rd%0d", r), 1'b0, addr_of(0, r), 8'h00, r % 3, VB0[r*8 +: 8]);
        tick();
        chk("B upd0", 64'({bank_upd, done}), 64'(3'b010));
        chk("B rd0", 64'(rd_data[47:0]), 64'(VB0));
        run_bank("B1", 1, VB1, 2);
        tick();
        chk("B upd1", 64'({bank_upd, done}), 64'(3'b100));
        chk("B rd1", 64'(rd_data[95:48]), 64'(VB1));
        chk("B rd0 kept", 64'(rd_data[47:0]), 64'(VB0));
        tick();
        chk("B done", 64'({done, busy, err}), 64'(3'b100));
        chk("B xact count", 64'(nx), 64'(14));
        tick();
        chk("B done pulse", 64'(done), 64'(0));

        // empty mask, then a stray ack while idle
        bank_mask = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("C done", 64'({done, busy, bus_req}), 64'(3'b100));
        tick();
        chk("C pulse", 64'({done, bus_req}), 64'(0));
        bus_ack = 1'b1;
        bus_rdata = 8'h77;
        tick();
        bus_ack = 1'b0;
        bus_rdata = 8'h00;
        tick();
        chk("C stray ack", 64'({busy, bus_req, bank_upd, done, err}), 64'(0));
        chk("C rd0 kept", 64'(rd_data[47:0]), 64'(VB0));

        // timeout on 3rd read of bank 1
        bank_mask = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_bank("D0", 0, VD0, 0);
        tick();
        chk("D upd0", 64'(bank_upd), 64'(2'b01));
        xact("D1 cmd", 1'b1, 8'hF2, 8'h01, 0, 8'h00);
        xact("D1 rd0", 1'b0, addr_of(1, 0), 8'h00, 0, 8'h71);
        xact("D1 rd1", 1'b0, addr_of(1, 1), 8'h00, 0, 8'h72);
        tick();
        chk("D rd2 addr", 64'({bus_req, bus_addr}), 64'({1'b1, addr_of(1, 2)}));
        n = 0;
        while (bus_req === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("D wait cycles", 64'(n), 64'(255));
        chk("D err", 64'({err, busy, done, bank_upd}), 64'(5'b10000));
        chk("D rd0", 64'(rd_data[47:0]), 64'(VD0));
        chk("D rd1 kept", 64'(rd_data[95:48]), 64'(VB1));
        tick();
        chk("D err pulse", 64'(err), 64'(0));

        // ack in the terminal wait cycle beats the timeout
        bank_mask = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        xact("E cmd", 1'b1, 8'hF2, 8'h01, 254, 8'h00);
        chk("E no timeout", 64'({err, busy}), 64'(2'b01));
        for (int r = 0; r < 6; r++)
            xact($sformatf("E rd%0d", r), 1'b0, addr_of(1, r), 8'h00, 1, VE1[r*8 +: 8]);
        tick();
        chk("E upd1", 64'(bank_upd), 64'(2'b10));
        chk("E rd1", 64'(rd_data[95:48]), 64'(VE1));
        tick();
        chk("E done", 64'({done, err}), 64'(2'b10));

        // non-BCD byte in bank 0
        bank_mask = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_bank("F0", 0, VF0, 0);
        tick();
`ifdef RTC_BCD_CHECK_EN
        chk("F upd0", 64'(bank_upd), 64'(2'b00));
        chk("F rd0", 64'(rd_data[47:0]), 64'(VD0));
`else
        chk("F upd0", 64'(bank_upd), 64'(2'b01));
        chk("F rd0", 64'(rd_data[47:0]), 64'(VF0));
`endif
        run_bank("F1", 1, VF1, 0);
        tick();
        chk("F upd1", 64'(bank_upd), 64'(2'b10));
        chk("F rd1", 64'(rd_data[95:48]), 64'(VF1));
        tick();
`ifdef RTC_BCD_CHECK_EN
        chk("F end", 64'({done, err, busy}), 64'(3'b010));
`else
        chk("F end", 64'({done, err, busy}), 64'(3'b100));
`endif

        // reset in the middle of a read request
        bank_mask = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        xact("R cmd", 1'b1, 8'hF1, 8'h01, 0, 8'h00);
        xact("R rd0", 1'b0, addr_of(0, 0), 8'h00, 0, 8'h99);
        tick();
        chk("R req before", 64'(bus_req), 64'(1));
        reset = 1'b1;
        #1;
        chk("R req drop", 64'(bus_req), 64'(0));
        chk("R ctl", 64'({bus_wr, busy, done, err, bank_upd}), 64'(0));
        chk("R rd0", 64'(rd_data[47:0]), 64'(0));
        chk("R rd1", 64'(rd_data[95:48]), 64'(0));
        tick();
        reset = 1'b0;
        tick();

        // normal sequence after reset
        bank_mask = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_bank("G", 0, VG0, 1);
        tick();
        chk("G upd", 64'(bank_upd), 64'(2'b01));
        chk("G rd0", 64'(rd_data[47:0]), 64'(VG0));
        chk("G rd1", 64'(rd_data[95:48]), 64'(0));
        tick();
        chk("G done", 64'({done, busy, err}), 64'(3'b100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
